// File: rtl/instr_defs.sv
// Instruction IDs shared by decoder, execution unit and memory stage,
// plus small decode helpers for the load/store subset.
package instr_defs;

    localparam logic [5:0] ID_ADD = 6'h01;
    localparam logic [5:0] ID_LB  = 6'h10;
    localparam logic [5:0] ID_LH  = 6'h11;
    localparam logic [5:0] ID_LW  = 6'h12;
    localparam logic [5:0] ID_LBU = 6'h13;
    localparam logic [5:0] ID_LHU = 6'h14;
    localparam logic [5:0] ID_SB  = 6'h18;
    localparam logic [5:0] ID_SH  = 6'h19;
    localparam logic [5:0] ID_SW  = 6'h1A;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } mem_size_e;

    function automatic logic is_load_id(input logic [5:0] id);
        return (id == ID_LB) || (id == ID_LH) || (id == ID_LW) ||
               (id == ID_LBU) || (id == ID_LHU);
    endfunction

    function automatic logic is_store_id(input logic [5:0] id);
        return (id == ID_SB) || (id == ID_SH) || (id == ID_SW);
    endfunction

    function automatic mem_size_e size_of(input logic [5:0] id);
        mem_size_e sz;
        case (id)
            ID_LB, ID_LBU, ID_SB: sz = SZ_B;
            ID_LH, ID_LHU, ID_SH: sz = SZ_H;
            default:              sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it according to the load opcode.
module load_align
    import instr_defs::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [5:0]  op_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = shifted[15:0];
        case (op_i)
            ID_LB:   result_o = {{24{byte_v[7]}}, byte_v};
            ID_LBU:  result_o = {24'h0, byte_v};
            ID_LH:   result_o = {{16{half_v[15]}}, half_v};
            ID_LHU:  result_o = {16'h0, half_v};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: one valid/ready request per aligned memory
// op, stalls the pipeline until the response is aligned into load_data_out.
module mem_access_unit
    import instr_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [5:0]  instr_id_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] store_data_in,
    output logic        mem_stall,
    output logic        misaligned_out,
    output logic [31:0] load_data_out,
    output logic        mem_done_out,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_req_addr,
    output logic        dmem_req_we,
    output logic [3:0]  dmem_req_wstrb,
    output logic [31:0] dmem_req_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP,
        ST_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_q, load_d;
    logic        we_q, we_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;

    logic        is_ld, is_st, is_mem, mis;
    mem_size_e   sz;
    logic [3:0]  strb_new;
    logic [31:0] wdata_new;
    logic [31:0] align_res;

    always_comb begin
        is_ld  = is_load_id(instr_id_in);
        is_st  = is_store_id(instr_id_in);
        is_mem = is_ld | is_st;
        sz     = size_of(instr_id_in);
        mis    = is_mem & (((sz == SZ_H) & mem_addr_in[0]) |
                           ((sz == SZ_W) & (mem_addr_in[1:0] != 2'b00)));
        case (sz)
            SZ_B: begin
                strb_new  = 4'b0001 << mem_addr_in[1:0];
                wdata_new = {4{store_data_in[7:0]}};
            end
            SZ_H: begin
                strb_new  = 4'b0011 << mem_addr_in[1:0];
                wdata_new = {2{store_data_in[15:0]}};
            end
            default: begin
                strb_new  = 4'b1111;
                wdata_new = store_data_in;
            end
        endcase
        if (!is_st) begin
            strb_new = 4'b0000;
        end
    end

    assign misaligned_out = valid_in & mis;
    // Stall drops in DONE so the pipeline advances on the same edge we return to IDLE.
    assign mem_stall      = valid_in & is_mem & ~mis & (state_q != ST_DONE);

    load_align u_load_align (
        .rdata_i  (dmem_rsp_rdata),
        .off_i    (off_q),
        .op_i     (op_q),
        .result_o (align_res)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        op_d    = op_q;
        off_d   = off_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_in && is_mem && !mis) begin
                    addr_d  = {mem_addr_in[31:2], 2'b00};
                    we_d    = is_st;
                    wstrb_d = strb_new;
                    wdata_d = wdata_new;
                    op_d    = instr_id_in;
                    off_d   = mem_addr_in[1:0];
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dmem_req_ready) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (dmem_rsp_valid) begin
                    if (is_load_id(op_q)) begin
                        load_d = align_res;
                    end
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= '0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            op_q    <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            op_q    <= op_d;
            off_q   <= off_d;
        end
    end

    assign dmem_req_valid = (state_q == ST_REQ);
    assign mem_done_out   = (state_q == ST_DONE);
    assign dmem_req_addr  = addr_q;
    assign dmem_req_we    = we_q;
    assign dmem_req_wstrb = wstrb_q;
    assign dmem_req_wdata = wdata_q;
    assign load_data_out  = load_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a cycle-scheduled reference model
// sets expectations that a negedge compare process checks every cycle.
module tb_mem_access_unit;
    import instr_defs::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [5:0]  instr_id_in = '0;
    logic [31:0] mem_addr_in = '0;
    logic [31:0] store_data_in = '0;
    logic        mem_stall, misaligned_out, mem_done_out;
    logic [31:0] load_data_out;
    logic        dmem_req_valid, dmem_req_we;
    logic        dmem_req_ready = 1'b0;
    logic [31:0] dmem_req_addr, dmem_req_wdata;
    logic [3:0]  dmem_req_wstrb;
    logic        dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_rsp_rdata = '0;

    mem_access_unit dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .instr_id_in    (instr_id_in),
        .mem_addr_in    (mem_addr_in),
        .store_data_in  (store_data_in),
        .mem_stall      (mem_stall),
        .misaligned_out (misaligned_out),
        .load_data_out  (load_data_out),
        .mem_done_out   (mem_done_out),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_req_addr  (dmem_req_addr),
        .dmem_req_we    (dmem_req_we),
        .dmem_req_wstrb (dmem_req_wstrb),
        .dmem_req_wdata (dmem_req_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_rdata (dmem_rsp_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // expectations for the current cycle
    bit          chk_en = 1'b0;
    bit          exp_stall, exp_mis, exp_done, exp_req_valid, exp_we;
    logic [31:0] exp_addr, exp_wdata, model_load;
    logic [3:0]  exp_wstrb;

    int          stall_cnt;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_wstrb;
    logic        last_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_stall", {31'b0, mem_stall}, {31'b0, exp_stall});
            chk("misaligned", {31'b0, misaligned_out}, {31'b0, exp_mis});
            chk("mem_done", {31'b0, mem_done_out}, {31'b0, exp_done});
            chk("req_valid", {31'b0, dmem_req_valid}, {31'b0, exp_req_valid});
            chk("load_data", load_data_out, model_load);
            if (exp_req_valid) begin
                chk("req_addr", dmem_req_addr, exp_addr);
                chk("req_we", {31'b0, dmem_req_we}, {31'b0, exp_we});
                chk("req_wstrb", {28'b0, dmem_req_wstrb}, {28'b0, exp_wstrb});
                if (exp_we) chk("req_wdata", dmem_req_wdata, exp_wdata);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int msize(input logic [5:0] id);
        case (id)
            ID_LB, ID_LBU, ID_SB: return 1;
            ID_LH, ID_LHU, ID_SH: return 2;
            ID_LW, ID_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit mstore(input logic [5:0] id);
        return (id == ID_SB) || (id == ID_SH) || (id == ID_SW);
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] id, input logic [31:0] rd, input int off);
        logic [31:0] v;
        v = rd >> (8 * off);
        case (id)
            ID_LB:  begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            ID_LBU: v = v % 256;
            ID_LH:  begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            ID_LHU: v = v % 65536;
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] m_strb(input logic [5:0] id, input int off);
        logic [3:0] s;
        int n;
        s = '0;
        n = msize(id);
        if (mstore(id))
            for (int i = 0; i < 4; i++) if (i >= off && i < off + n) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] id, input logic [31:0] sd);
        logic [31:0] w;
        int n;
        n = msize(id);
        w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
        return w;
    endfunction

    // ---------------- cycle helpers ----------------
    task automatic begin_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic end_cycle();
        @(negedge clk);
        #1;
        if (mem_stall) stall_cnt++;
        if (dmem_req_valid) begin
            last_addr  = dmem_req_addr;
            last_wdata = dmem_req_wdata;
            last_wstrb = dmem_req_wstrb;
            last_we    = dmem_req_we;
        end
    endtask

    task automatic set_exp(input bit st, input bit mi, input bit dn, input bit rv);
        exp_stall = st; exp_mis = mi; exp_done = dn; exp_req_valid = rv;
    endtask

    task automatic idle_cycle();
        begin_cycle();
        valid_in       = 1'b0;
        instr_id_in    = 6'($urandom);
        mem_addr_in    = $urandom;
        dmem_req_ready = 1'($urandom);
        dmem_rsp_valid = ($urandom % 4 == 0);
        dmem_rsp_rdata = $urandom;
        set_exp(0, 0, 0, 0);
        end_cycle();
    endtask

    task automatic do_op(input logic [5:0] id, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rd, input int nrl, input int nrsp);
        int  n;
        bit  mis;
        n   = msize(id);
        mis = (n > 0) && (addr % n != 0);
        stall_cnt = 0;

        begin_cycle();
        valid_in       = 1'b1;
        instr_id_in    = id;
        mem_addr_in    = addr;
        store_data_in  = sd;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = ($urandom % 4 == 0);
        dmem_rsp_rdata = $urandom;
        if (n == 0 || mis) begin
            set_exp(0, mis, 0, 0);
            end_cycle();
            return;
        end
        set_exp(1, 0, 0, 0);
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_we    = mstore(id);
        exp_wstrb = m_strb(id, int'(addr % 4));
        exp_wdata = m_wdata(id, sd);
        end_cycle();

        for (int k = 0; k <= nrl; k++) begin
            begin_cycle();
            dmem_req_ready = (k == nrl);
            dmem_rsp_valid = ($urandom % 3 == 0);
            dmem_rsp_rdata = $urandom;
            set_exp(1, 0, 0, 1);
            end_cycle();
        end

        for (int k = 0; k <= nrsp; k++) begin
            begin_cycle();
            dmem_req_ready = 1'($urandom);
            dmem_rsp_valid = (k == nrsp);
            dmem_rsp_rdata = (k == nrsp) ? rd : $urandom;
            set_exp(1, 0, 0, 0);
            end_cycle();
        end

        begin_cycle();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = ($urandom % 3 == 0);
        dmem_rsp_rdata = $urandom;
        if (!mstore(id)) model_load = m_load(id, rd, int'(addr % 4));
        set_exp(0, 0, 1, 0);
        end_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [5:0] id_pool [10];

    initial begin
        logic [5:0]  id;
        logic [31:0] a;
        int          n;
        id_pool = '{ID_LB, ID_LH, ID_LW, ID_LBU, ID_LHU, ID_SB, ID_SH, ID_SW, ID_ADD, 6'h2A};
        model_load = '0;
        set_exp(0, 0, 0, 0);
        exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", {31'b0, dmem_req_valid}, 32'd0);
        chk("rst_done", {31'b0, mem_done_out}, 32'd0);
        chk("rst_load", load_data_out, 32'd0);
        chk("rst_addr", dmem_req_addr, 32'd0);
        chk("rst_wstrb", {28'b0, dmem_req_wstrb}, 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        idle_cycle();

        // directed cases with hand-computed results
        do_op(ID_SW, 32'h100, 32'hDEADBEEF, $urandom, 0, 0);
        chk("sw_stall_cycles", stall_cnt, 32'd3);
        chk("sw_done_pulse", {31'b0, mem_done_out}, 32'd1);
        chk("sw_addr", last_addr, 32'h100);
        chk("sw_wstrb", {28'b0, last_wstrb}, 32'hF);
        chk("sw_wdata", last_wdata, 32'hDEADBEEF);
        chk("sw_we", {31'b0, last_we}, 32'd1);

        do_op(ID_LB, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
        chk("lb_result", load_data_out, 32'hFFFF_FF80);
        do_op(ID_LBU, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
        chk("lbu_result", load_data_out, 32'h0000_0080);
        do_op(ID_SB, 32'h102, 32'h0000_00AB, $urandom, 0, 1);
        chk("sb_wstrb", {28'b0, last_wstrb}, 32'h4);
        chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
        chk("sb_keeps_load", load_data_out, 32'h0000_0080);
        do_op(ID_LH, 32'h102, 32'h0, 32'h8001_1234, 0, 0);
        chk("lh_result", load_data_out, 32'hFFFF_8001);
        do_op(ID_LHU, 32'h100, 32'h0, 32'h8001_1234, 0, 0);
        chk("lhu_result", load_data_out, 32'h0000_1234);
        do_op(ID_LW, 32'h200, 32'h0, 32'h1234_5678, 4, 0);
        chk("lw_stall_cycles", stall_cnt, 32'd7);
        chk("lw_result", load_data_out, 32'h1234_5678);
        chk("lw_addr", last_addr, 32'h200);

        do_op(ID_LW, 32'h101, 32'h0, 32'h0, 0, 0);
        chk("mis_flag", {31'b0, misaligned_out}, 32'd1);
        chk("mis_no_req", {31'b0, dmem_req_valid}, 32'd0);
        chk("mis_no_stall", {31'b0, mem_stall}, 32'd0);
        do_op(ID_ADD, 32'h100, 32'h5, 32'h0, 0, 0);
        chk("add_no_stall", {31'b0, mem_stall}, 32'd0);
        chk("add_no_req", {31'b0, dmem_req_valid}, 32'd0);

        // randomized traffic, back-to-back with occasional bubbles
        for (int i = 0; i < 250; i++) begin
            if ($urandom % 8 == 0) idle_cycle();
            id = id_pool[$urandom % 10];
            a  = $urandom;
            n  = msize(id);
            if (n > 0 && ($urandom % 4 != 0)) a = a & ~32'(n - 1);
            do_op(id, a, $urandom, $urandom, int'($urandom % 4), int'($urandom % 4));
        end

        // reset while waiting for a response
        do_op(ID_LW, 32'h300, 32'h0, 32'hCAFE_F00D, 0, 0);
        begin_cycle();
        valid_in = 1'b1; instr_id_in = ID_LW; mem_addr_in = 32'h304;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        set_exp(1, 0, 0, 0);
        end_cycle();
        begin_cycle();
        dmem_req_ready = 1'b1;
        set_exp(1, 0, 0, 1);
        exp_addr = 32'h304; exp_we = 0; exp_wstrb = 4'h0;
        end_cycle();
        begin_cycle();
        dmem_req_ready = 1'b0;
        set_exp(1, 0, 0, 0);
        end_cycle();
        begin_cycle();
        chk_en   = 1'b0;
        rst      = 1'b1;
        valid_in = 1'b0;
        #1;
        chk("arst_req_valid", {31'b0, dmem_req_valid}, 32'd0);
        chk("arst_addr", dmem_req_addr, 32'd0);
        chk("arst_wdata", dmem_req_wdata, 32'd0);
        chk("arst_we", {31'b0, dmem_req_we}, 32'd0);
        chk("arst_wstrb", {28'b0, dmem_req_wstrb}, 32'd0);
        chk("arst_load", load_data_out, 32'd0);
        chk("arst_done", {31'b0, mem_done_out}, 32'd0);
        chk("arst_stall", {31'b0, mem_stall}, 32'd0);
        begin_cycle();
        rst            = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hFFFF_FFFF;
        model_load     = '0;
        set_exp(0, 0, 0, 0);
        chk_en = 1'b1;
        end_cycle();
        repeat (4) idle_cycle();
        dmem_rsp_valid = 1'b0;
        do_op(ID_LBU, 32'h401, 32'h0, 32'h0000_5A00, 1, 2);
        chk("post_rst_lbu", load_data_out, 32'h0000_005A);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
